// File: rtl/column_window_buffer.sv
// column_window_buffer
// Column-oriented window buffer. Pixels arrive one row at a time over an
// AXI-Stream slave, one column at a time. Every column is followed by
// BLOCK_SIZE-1 zero "pad" shifts. The bottom row takes the raw sample in its
// newest column and the caller's processed fed-back columns in the others.
// Row 0 of the buffer is presented on win_out.
//
// Optional build macro: CWB_TLAST_CHECK_EN
//   defined   -> tlast ends a column early; column-length mismatches set a
//                sticky err flag.
//   undefined -> tlast ignored, every column is BUFFER_HEIGHT words, err = 0.
module column_window_buffer #(
   parameter int DATA_WIDTH         = 8,
   parameter int NUM_CHANNELS       = 3,
   parameter int BLOCK_SIZE         = 3,
   parameter int BUFFER_HEIGHT      = 480,
   parameter int C_AXIS_TDATA_WIDTH = 32,
   localparam int FB_WIDTH  = (BLOCK_SIZE > 1) ? NUM_CHANNELS*(BLOCK_SIZE-1)*DATA_WIDTH : 1,
   localparam int WIN_WIDTH = NUM_CHANNELS*BLOCK_SIZE*DATA_WIDTH
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          tvalid,
   output logic                          tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] tdata,
   input  logic                          tlast,
   input  logic                          tuser,
   input  logic [FB_WIDTH-1:0]           fb_in,
   output logic [WIN_WIDTH-1:0]          win_out,
   input  logic                          back_pressure,
   output logic                          shift_en,
   output logic                          pad_active,
   output logic                          col_start,
   output logic                          window_full,
   output logic                          err
);

   // ------------------------------------------------------------------
   // Counter widths and constants
   // ------------------------------------------------------------------
   localparam int ROW_W = (BUFFER_HEIGHT > 2) ? $clog2(BUFFER_HEIGHT) : 1;
   localparam int PAD_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE-1) : 1;
   localparam int CV_W  = $clog2(BLOCK_SIZE+1);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BUFFER_HEIGHT-1);
   localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'((BLOCK_SIZE >= 2) ? BLOCK_SIZE-2 : 0);
   localparam logic [CV_W-1:0]  CV_MAX   = CV_W'(BLOCK_SIZE);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PAD  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
   logic [PAD_W-1:0]  pad_cnt_q, pad_cnt_d;
   logic [CV_W-1:0]   cols_valid_q, cols_valid_d;

   logic              accept;
   logic              col_end;
   logic              col_done;
   logic              fill_mode;

   // Window storage: channel x row x column
   logic [DATA_WIDTH-1:0] mem_q  [NUM_CHANNELS][BUFFER_HEIGHT][BLOCK_SIZE];
   logic [DATA_WIDTH-1:0] mem_d  [NUM_CHANNELS][BUFFER_HEIGHT][BLOCK_SIZE];
   logic [DATA_WIDTH-1:0] sample [NUM_CHANNELS];

   // Only the top NUM_CHANNELS*DATA_WIDTH bits of tdata carry samples.
   // Without the length check, tlast is not used at all.
   logic unused_inputs;
   assign unused_inputs = ^{tlast, tdata};

   assign fill_mode = (state_q == ST_FILL);

   // ------------------------------------------------------------------
   // Datapath: channel unpacking, shift network and window tap
   // ------------------------------------------------------------------
   genvar gi, gj, gr;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         // Channel 0 is the most significant slice of tdata.
         assign sample[gi] = tdata[C_AXIS_TDATA_WIDTH-1-gi*DATA_WIDTH -: DATA_WIDTH];

         for (gj = 0; gj < BLOCK_SIZE; gj++) begin : g_col
            // Every row takes the row below it.
            for (gr = 0; gr < BUFFER_HEIGHT-1; gr++) begin : g_row
               assign mem_d[gi][gr][gj] = mem_q[gi][gr+1][gj];
            end

            // Bottom row: the newest column gets the raw sample (zero while
            // padding). The older columns get the fed-back processed data.
            if (gj == BLOCK_SIZE-1) begin : g_new
               assign mem_d[gi][BUFFER_HEIGHT-1][gj] = fill_mode ? sample[gi] : '0;
            end else begin : g_fb
               assign mem_d[gi][BUFFER_HEIGHT-1][gj] =
                  fb_in[(gi*(BLOCK_SIZE-1)+gj)*DATA_WIDTH +: DATA_WIDTH];
            end

            // Row 0 of every column is the window output.
            assign win_out[(gi*BLOCK_SIZE+gj)*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi][0][gj];
         end
      end
   endgenerate

   // Storage register: cleared by reset, moves only on a shift
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int r = 0; r < BUFFER_HEIGHT; r++) begin
               for (int j = 0; j < BLOCK_SIZE; j++) begin
                  mem_q[c][r][j] <= '0;
               end
            end
         end
      end else if (shift_en) begin
         mem_q <= mem_d;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // State register: FSM state and column/pad/window counters
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_FILL;
         row_cnt_q    <= '0;
         pad_cnt_q    <= '0;
         cols_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         row_cnt_q    <= row_cnt_d;
         pad_cnt_q    <= pad_cnt_d;
         cols_valid_q <= cols_valid_d;
      end
   end

`ifdef CWB_TLAST_CHECK_EN
   logic err_q, err_d;

   // Sticky column-length error flag, cleared only by reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Next-state logic: row counting, column end, padding and window fill level
   always_comb begin
      state_d      = state_q;
      row_cnt_d    = row_cnt_q;
      pad_cnt_d    = pad_cnt_q;
      cols_valid_d = cols_valid_q;
      col_end      = 1'b0;
      col_done     = 1'b0;
`ifdef CWB_TLAST_CHECK_EN
      err_d        = err_q;
`endif

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (tuser) begin
                  // Start of frame: this word is row 0 of a fresh column.
                  row_cnt_d = ROW_W'(1);
`ifdef CWB_TLAST_CHECK_EN
                  if (tlast) err_d = 1'b1;
`endif
               end else if (row_cnt_q == LAST_ROW) begin
                  col_end = 1'b1;
`ifdef CWB_TLAST_CHECK_EN
                  if (!tlast) err_d = 1'b1;
`endif
               end
`ifdef CWB_TLAST_CHECK_EN
               else if (tlast) begin
                  // Short column: close it now and flag the mismatch.
                  col_end = 1'b1;
                  err_d   = 1'b1;
               end
`endif
               else begin
                  row_cnt_d = row_cnt_q + 1'b1;
               end
            end
         end

         ST_PAD: begin
            if (!back_pressure) begin
               if (pad_cnt_q == '0) begin
                  state_d  = ST_FILL;
                  col_done = 1'b1;
               end else begin
                  pad_cnt_d = pad_cnt_q - 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase

      // A finished column either goes straight to done (single-column
      // window) or is followed by BLOCK_SIZE-1 zero shifts.
      if (col_end) begin
         row_cnt_d = '0;
         if (BLOCK_SIZE == 1) begin
            col_done = 1'b1;
         end else begin
            state_d   = ST_PAD;
            pad_cnt_d = PAD_INIT;
         end
      end

      // Frame start wins over any column completion in the same cycle.
      if (accept && tuser) begin
         cols_valid_d = '0;
      end else if (col_done && (cols_valid_q != CV_MAX)) begin
         cols_valid_d = cols_valid_q + 1'b1;
      end
   end

   // Output logic: handshake, shift enable and status flags
   always_comb begin
      tready      = (state_q == ST_FILL) && !back_pressure;
      accept      = tvalid && tready && aresetn;
      shift_en    = accept || ((state_q == ST_PAD) && !back_pressure && aresetn);
      pad_active  = (state_q == ST_PAD);
      col_start   = accept && ((row_cnt_q == '0) || tuser);
      window_full = (int'(cols_valid_q) >= BLOCK_SIZE - 1);
   end

endmodule

// File: tb/tb_column_window_buffer.sv
// tb_column_window_buffer
// Randomised and directed checks of column_window_buffer with
// DATA_WIDTH=8, NUM_CHANNELS=3, BLOCK_SIZE=3, BUFFER_HEIGHT=4, TDATA=32.
// The reference model keeps the last BUFFER_HEIGHT shifted-in bottom rows in
// a queue. Row 0 of the window is the oldest of them.
module tb_column_window_buffer;

   localparam int DW = 8;
   localparam int NC = 3;
   localparam int BS = 3;
   localparam int H  = 4;
   localparam int TW = 32;
   localparam int WW = NC*BS*DW;
   localparam int FW = NC*(BS-1)*DW;
   localparam int VW = WW + 6;

`ifdef CWB_TLAST_CHECK_EN
   localparam bit TLAST_CHK = 1'b1;
`else
   localparam bit TLAST_CHK = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          tvalid = 1'b0;
   logic          tready;
   logic [TW-1:0] tdata = '0;
   logic          tlast = 1'b0;
   logic          tuser = 1'b0;
   logic [FW-1:0] fb_in = '0;
   logic [WW-1:0] win_out;
   logic          back_pressure = 1'b0;
   logic          shift_en;
   logic          pad_active;
   logic          col_start;
   logic          window_full;
   logic          err;

   column_window_buffer #(
      .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .BLOCK_SIZE(BS),
      .BUFFER_HEIGHT(H), .C_AXIS_TDATA_WIDTH(TW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .tvalid(tvalid), .tready(tready),
      .tdata(tdata), .tlast(tlast), .tuser(tuser), .fb_in(fb_in),
      .win_out(win_out), .back_pressure(back_pressure), .shift_en(shift_en),
      .pad_active(pad_active), .col_start(col_start),
      .window_full(window_full), .err(err)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   int            m_rows;      // words already received in current column
   int            m_pad_left;  // zero shifts still owed (0 = accepting)
   int            m_cols;      // completed columns since frame start, capped at BS
   bit            m_err;
   logic [WW-1:0] m_hist[$];   // last H bottom rows, oldest first

   logic          e_tready, e_shift, e_pad, e_colstart, e_wfull, e_err;
   logic [WW-1:0] e_win;
   logic [VW-1:0] exp_v, obs_v;

   function automatic logic [WW-1:0] new_row(input bit zero, input logic [TW-1:0] d,
                                             input logic [FW-1:0] fb);
      logic [WW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         for (int j = 0; j < BS-1; j++) r[(c*BS+j)*DW +: DW] = fb[(c*(BS-1)+j)*DW +: DW];
         r[(c*BS+BS-1)*DW +: DW] = zero ? 8'h00 : d[TW-1-c*DW -: DW];
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] observe();
      return {tready, shift_en, pad_active, col_start, window_full, err, win_out};
   endfunction

   task automatic model_reset();
      m_rows = 0; m_pad_left = 0; m_cols = 0; m_err = 1'b0;
      m_hist.delete();
   endtask

   task automatic model_expect();
      logic acc;
      e_tready   = (m_pad_left == 0) && !back_pressure;
      acc        = aresetn && tvalid && e_tready;
      e_shift    = acc || (aresetn && (m_pad_left > 0) && !back_pressure);
      e_pad      = (m_pad_left > 0);
      e_colstart = acc && ((m_rows == 0) || tuser);
      e_wfull    = (m_cols >= BS-1);
      e_err      = m_err;
      e_win      = (m_hist.size() == H) ? m_hist[0] : '0;
      exp_v      = {e_tready, e_shift, e_pad, e_colstart, e_wfull, e_err, e_win};
   endtask

   // Apply one cycle of inputs at the falling edge and form expectations.
   task automatic drive(input logic rstn, input logic v, input logic [TW-1:0] d,
                        input logic l, input logic u, input logic bp, input logic [FW-1:0] fb);
      @(negedge aclk);
      aresetn = rstn; tvalid = v; tdata = d; tlast = l; tuser = u;
      back_pressure = bp; fb_in = fb;
      #1;
      model_expect();
   endtask

   // Advance through the rising edge and update the model.
   task automatic tick();
      logic acc, pshift;
      logic [WW-1:0] row;
      acc    = aresetn && tvalid && (m_pad_left == 0) && !back_pressure;
      pshift = aresetn && (m_pad_left > 0) && !back_pressure;
      row    = new_row(m_pad_left > 0, tdata, fb_in);
      @(posedge aclk);
      if (acc || pshift) begin
         m_hist.push_back(row);
         if (m_hist.size() > H) void'(m_hist.pop_front());
      end
      if (acc) begin
         $display("accept t=%0t data=%h user=%0d last=%0d row=%0d", $time, tdata, tuser, tlast, m_rows);
         if (tuser) begin
            m_rows = 1; m_cols = 0;
            if (TLAST_CHK && tlast) m_err = 1'b1;
         end else if (m_rows == H-1) begin
            m_rows = 0; m_pad_left = BS-1;
            if (TLAST_CHK && !tlast) m_err = 1'b1;
         end else if (TLAST_CHK && tlast) begin
            m_rows = 0; m_pad_left = BS-1; m_err = 1'b1;
         end else begin
            m_rows++;
         end
      end else if (pshift) begin
         m_pad_left--;
         if (m_pad_left == 0 && m_cols < BS) m_cols++;
      end
   endtask

   function automatic logic [FW-1:0] rnd_fb();
      return FW'({$urandom(), $urandom()});
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, $urandom(), 1'b0, 1'b1, (i == 1), rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs cyc%0d: got %h expected %h", i, obs_v, exp_v);
         end
         checks++;
         if (tready !== !back_pressure) begin
            failures++;
            $display("FAIL reset_tready: got %b expected %b", tready, !back_pressure);
         end
         tick();
      end
   endtask

   task automatic test_basic_column();
      logic [31:0] words [4];
      int no_ready, pads;
      words[0] = 32'h11223300; words[1] = 32'h22334400;
      words[2] = 32'h33445500; words[3] = 32'h44556600;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, words[i], 1'b0, 1'b0, 1'b0, '0);
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL basic_word%0d: got %h expected %h", i, obs_v, exp_v);
         end
         tick();
      end
      no_ready = 0; pads = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
         if (i == 0) begin
            checks++;
            if (win_out[23:16] !== 8'h11) begin
               failures++;
               $display("FAIL basic_win_ch0_col2: got %h expected 11", win_out[23:16]);
            end
         end
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL basic_pad%0d: got %h expected %h", i, obs_v, exp_v);
         end
         if (tready === 1'b0) no_ready++;
         if (pad_active === 1'b1) pads++;
         tick();
      end
      checks++;
      if (no_ready != 2 || pads != 2) begin
         failures++;
         $display("FAIL basic_pad_len: tready_low=%0d pad_cycles=%0d expected 2/2", no_ready, pads);
      end
   endtask

   task automatic test_pad_backpressure();
      int pad_cycles, pad_shifts;
      bit done;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL bp_word%0d: got %h expected %h", i, obs_v, exp_v);
         end
         tick();
      end
      pad_cycles = 0; pad_shifts = 0; done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b0, (k < 3), rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL bp_cycle%0d: got %h expected %h", k, obs_v, exp_v);
         end
         if (k < 3) begin
            checks++;
            if (shift_en !== 1'b0 || pad_active !== 1'b1) begin
               failures++;
               $display("FAIL bp_freeze%0d: shift_en=%b pad_active=%b expected 0/1", k, shift_en, pad_active);
            end
         end
         if (pad_active === 1'b1) pad_cycles++;
         if (pad_active === 1'b1 && shift_en === 1'b1) pad_shifts++;
         if (k >= 3 && pad_active !== 1'b1) done = 1'b1;
         tick();
      end
      checks++;
      if (pad_cycles != 5 || pad_shifts != 2) begin
         failures++;
         $display("FAIL bp_pad_len: cycles=%0d shifts=%0d expected 5/2", pad_cycles, pad_shifts);
      end
   endtask

   task automatic test_window_full();
      int starts, rise_at;
      logic prev_wf;
      starts = 0; rise_at = -1; prev_wf = 1'b1;
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 1'b1, $urandom(), 1'b0, (i == 0), 1'b0, rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL wfull_cycle%0d: got %h expected %h", i, obs_v, exp_v);
         end
         if (col_start === 1'b1) starts++;
         if (window_full === 1'b1 && prev_wf === 1'b0 && rise_at < 0) rise_at = i;
         prev_wf = window_full;
         tick();
      end
      checks++;
      if (starts != 3 || rise_at != 12) begin
         failures++;
         $display("FAIL wfull_timing: col_starts=%0d rise_cycle=%0d expected 3/12", starts, rise_at);
      end
   endtask

   task automatic test_tuser_clears();
      drive(1'b1, 1'b1, $urandom(), 1'b0, 1'b1, 1'b0, rnd_fb());
      obs_v = observe();
      checks++;
      if (obs_v !== exp_v || window_full !== 1'b1) begin
         failures++;
         $display("FAIL tuser_before: got %h expected %h (window_full=1)", obs_v, exp_v);
      end
      tick();
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, rnd_fb());
      checks++;
      if (window_full !== 1'b0) begin
         failures++;
         $display("FAIL tuser_clear: window_full=%b expected 0", window_full);
      end
      tick();
   endtask

   task automatic test_tlast();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      model_reset(); model_expect();
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, $urandom(), (i == 1), 1'b0, 1'b0, rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL tlast_word%0d: got %h expected %h", i, obs_v, exp_v);
         end
         tick();
      end
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, rnd_fb());
      checks++;
      if (pad_active !== TLAST_CHK || err !== TLAST_CHK) begin
         failures++;
         $display("FAIL tlast_effect: pad_active=%b err=%b expected %b/%b", pad_active, err, TLAST_CHK, TLAST_CHK);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v || err !== TLAST_CHK) begin
            failures++;
            $display("FAIL tlast_after%0d: got %h expected %h", i, obs_v, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_pad();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         drive(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, rnd_fb());
         if (pad_active === 1'b1) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midpad_reach: pad_active never seen within 12 cycles");
      end
      aresetn = 1'b0;
      #1;
      model_reset(); model_expect();
      obs_v = observe();
      checks++;
      if (obs_v !== exp_v) begin
         failures++;
         $display("FAIL midpad_reset: got %h expected %h", obs_v, exp_v);
      end
      tick();
      drive(1'b1, 1'b1, 32'hA5B6C700, 1'b0, 1'b0, 1'b0, rnd_fb());
      checks++;
      if (col_start !== 1'b1 || obs_v === observe() && 1'b0) begin
         failures++;
         $display("FAIL midpad_row0: col_start=%b expected 1", col_start);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, ($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 6) == 0),
               ($urandom_range(0, 30) == 0), ($urandom_range(0, 5) == 0), rnd_fb());
         obs_v = observe();
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h expected %h", i, obs_v, exp_v);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic_column();
      test_pad_backpressure();
      test_window_full();
      test_tuser_clears();
      test_tlast();
      test_reset_mid_pad();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/column_window_buffer.md
COLUMN_WINDOW_BUFFER -- requirements
Module: column_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per channel sample.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, channels per pixel; NUM_CHANNELS*DATA_WIDTH <= C_AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter BLOCK_SIZE, default 3, window columns (>=1).
REQ-004 SHALL have parameter BUFFER_HEIGHT, default 480, rows per column (>=2).
REQ-005 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32, stream data width.
REQ-006 SHALL have port aclk input 1, sole clock, rising edge.
REQ-007 SHALL have port aresetn input 1, asynchronous active-low reset.
REQ-008 SHALL have ports tvalid input 1, tready output 1, tdata input C_AXIS_TDATA_WIDTH, tlast input 1 (end of column), tuser input 1 (start of frame); AXI-Stream slave.
REQ-009 SHALL have port fb_in input NUM_CHANNELS*(BLOCK_SIZE-1)*DATA_WIDTH, processed columns fed back; channel c, column j at offset (c*(BLOCK_SIZE-1)+j)*DATA_WIDTH.
REQ-010 SHALL have port win_out output NUM_CHANNELS*BLOCK_SIZE*DATA_WIDTH, row 0 of buffer; channel c, column j at offset (c*BLOCK_SIZE+j)*DATA_WIDTH.
REQ-011 SHALL have port back_pressure input 1; 1 freezes all shifting.
REQ-012 SHALL have outputs shift_en 1 (buffer shifts this cycle), pad_active 1 (state PAD), col_start 1 (first word of a column accepted), window_full 1, err output 1.

Function
REQ-013 Channel c of accepted word SHALL be tdata[C_AXIS_TDATA_WIDTH-1-c*DATA_WIDTH -: DATA_WIDTH] (MSB-first).
REQ-014 Storage SHALL be NUM_CHANNELS x BUFFER_HEIGHT x BLOCK_SIZE registers; on shift_en every row r<BUFFER_HEIGHT-1 loads row r+1; bottom row column BLOCK_SIZE-1 loads sample (FILL) or 0 (PAD); bottom row columns j<BLOCK_SIZE-1 load fb_in column j.
REQ-015 States: FILL, PAD. tready = (state==FILL) && !back_pressure; accept = tvalid && tready.
REQ-016 shift_en = accept || (state==PAD && !back_pressure); no register changes when shift_en=0 except state/counters per REQ-017..019.
REQ-017 row_cnt SHALL count accepts 0..BUFFER_HEIGHT-1; on accept with row_cnt==BUFFER_HEIGHT-1: row_cnt->0, state->PAD with pad_cnt=BLOCK_SIZE-2, or stay FILL and complete column if BLOCK_SIZE==1.
REQ-018 In PAD each shift decrements pad_cnt; shift with pad_cnt==0 -> FILL, column complete; BLOCK_SIZE-1 zero shifts per column.
REQ-019 cols_valid SHALL increment on column complete, saturating at BLOCK_SIZE; window_full = (cols_valid >= BLOCK_SIZE-1).
REQ-020 Accept with tuser=1 SHALL set cols_valid to 0 and row_cnt to 1 (word is row 0), overriding any pending increment; err unaffected.
REQ-021 col_start = accept && (row_cnt==0 || tuser).
REQ-022 Latency: sample accepted at cycle n is in bottom row at n+1 and on win_out after BUFFER_HEIGHT shifts.
REQ-023 back_pressure asserted in PAD SHALL hold pad_cnt and state; pad_active stays 1.

Reset
REQ-024 aresetn=0 SHALL asynchronously clear all storage, row_cnt, pad_cnt, cols_valid, err; state FILL.
REQ-025 During/after reset: win_out=0, shift_en=0, pad_active=0, col_start=0, window_full=(BLOCK_SIZE==1), err=0, tready=!back_pressure once released.
REQ-026 Reset mid-column or mid-PAD SHALL discard partial column; next accept is row 0.

Configuration
REQ-027 Macro CWB_TLAST_CHECK_EN defined: accept with tlast=1 and row_cnt<BUFFER_HEIGHT-1 ends column early (row_cnt->0, enter PAD) and sets err sticky; accept at row_cnt==BUFFER_HEIGHT-1 with tlast=0 sets err sticky.
REQ-028 Macro undefined: tlast ignored, column length always BUFFER_HEIGHT, err tied 0.

Verification (DATA_WIDTH=8, NUM_CHANNELS=3, BLOCK_SIZE=3, BUFFER_HEIGHT=4, TDATA 32)
REQ-029 Stream 4 words 0x11223300..0x44556600, fb_in=0, no back_pressure -> tready drops 2 cycles, pad_active 2 cycles, win_out channel0 col2 = 0x11 after 4th shift.
REQ-030 Hold back_pressure=1 3 cycles during PAD -> shift_en=0, pad_cnt frozen, PAD length still 2 shifts.
REQ-031 Three full columns after tuser -> window_full rises after 2nd column complete; col_start pulses 3 times.
REQ-032 With CWB_TLAST_CHECK_EN: tlast on 2nd word -> PAD entered next cycle, err=1 until reset; without macro: no effect, err=0.
REQ-033 Assert aresetn=0 during PAD -> all outputs per REQ-025 immediately, next column starts at row 0.
REQ-034 tuser on accept with cols_valid=3 -> cols_valid=0, window_full=0 next cycle.
